// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared types and constants for the branch resolve unit:
//   - pred_rec_t  : one in-flight prediction record {pc, target, taken, way}.
//                   Address fields are REC_ADDR_W wide; narrower instances
//                   zero-extend into them and truncate on the way out.
//   - bru_state_t : resolve-unit FSM state (RUN / RECOVER).
//   - INSN_BYTES  : fall-through increment used for not-taken redirects.
//   - sat_inc32   : saturating 32-bit increment used by the event counters.
// -----------------------------------------------------------------------------
package branch_pkg;

    localparam int REC_ADDR_W = 64;
    localparam int INSN_BYTES = 4;

    typedef struct packed {
        logic [REC_ADDR_W-1:0] pc;
        logic [REC_ADDR_W-1:0] target;
        logic                  taken;
        logic [1:0]            way;
    } pred_rec_t;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } bru_state_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// -----------------------------------------------------------------------------
// pred_fifo
// Synchronous FIFO holding in-flight prediction records.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clear        : synchronous flush of all entries (wins over push/pop)
//   push, push_data : write request and data (ignored when full)
//   pop          : remove the head entry (ignored when empty)
//   head_data    : oldest entry, valid whenever empty == 0
//   full, empty  : current occupancy flags
//   full_next    : occupancy flag the FIFO will show after this edge, so the
//                  owner can present a registered ready without a lag cycle
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module pred_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic             full_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign head_data = mem_r[rd_ptr_r];
    assign full_next = (count_s == CNT_W'(DEPTH));

    // Accepted push/pop and the occupancy after this edge.
    always_comb begin
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
        count_s   = count_r;
        if (clear) begin
            count_s = {CNT_W{1'b0}};
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_s = count_r + CNT_W'(1);
                2'b01:   count_s = count_r - CNT_W'(1);
                default: count_s = count_r;
            endcase
        end
    end

    // Pointer and occupancy registers; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_s;
        end
    end

    // Record storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s & ~clear & ~rst) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Keeps fetch-time branch predictions in order, compares each against the
// execute-stage outcome, redirects fetch on a mispredict and emits predictor
// training updates.
// Ports:
//   i_clk, i_arst              : clock, synchronous active-high reset
//   i_push_* / o_push_ready    : prediction record from fetch (pc, target,
//                                taken, way); ready = queue not full
//   i_res_*                    : resolution of the oldest in-flight instruction
//   i_flush                    : external flush, overrides everything else
//   o_redirect_valid/_pc       : one-cycle fetch redirect pulse
//   o_upd_*                    : one-cycle predictor training pulse
//   o_underflow                : sticky, a resolve found the queue empty
//   o_br_count / o_mp_count    : saturating branch / mispredict counters
// All outputs are registered and appear one cycle after the resolving edge.
// ADDR_WIDTH must not exceed branch_pkg::REC_ADDR_W.
// -----------------------------------------------------------------------------
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_push_valid,
    input  logic [ADDR_WIDTH-1:0] i_push_pc,
    input  logic [ADDR_WIDTH-1:0] i_push_target,
    input  logic                  i_push_taken,
    input  logic [1:0]            i_push_way,
    output logic                  o_push_ready,
    input  logic                  i_res_valid,
    input  logic                  i_res_branch,
    input  logic                  i_res_taken,
    input  logic [ADDR_WIDTH-1:0] i_res_target,
    input  logic                  i_flush,
    output logic                  o_redirect_valid,
    output logic [ADDR_WIDTH-1:0] o_redirect_pc,
    output logic                  o_upd_valid,
    output logic                  o_upd_taken,
    output logic [ADDR_WIDTH-1:0] o_upd_pc,
    output logic [ADDR_WIDTH-1:0] o_upd_target,
    output logic [1:0]            o_upd_way,
    output logic                  o_underflow,
    output logic [31:0]           o_br_count,
    output logic [31:0]           o_mp_count
);

    localparam int REC_W = $bits(pred_rec_t);

    bru_state_t            state_r;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic                  fifo_full_next_s;
    logic [REC_W-1:0]      head_bits_s;
    pred_rec_t             push_rec_s;
    pred_rec_t             head_rec_s;
    logic [ADDR_WIDTH-1:0] head_pc_s;
    logic [ADDR_WIDTH-1:0] head_target_s;
    logic [ADDR_WIDTH-1:0] redirect_pc_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  upd_s;
    logic                  underflow_s;
    logic                  target_miss_s;
    logic                  mispredict_s;
    logic                  clear_s;

    // Decode of this cycle's push/resolve/flush into queue and output actions.
    always_comb begin
        push_rec_s.pc     = REC_ADDR_W'(i_push_pc);
        push_rec_s.target = REC_ADDR_W'(i_push_target);
        push_rec_s.taken  = i_push_taken;
        push_rec_s.way    = i_push_way;

        head_rec_s    = head_bits_s;
        head_pc_s     = ADDR_WIDTH'(head_rec_s.pc);
        head_target_s = ADDR_WIDTH'(head_rec_s.target);

        // A flush cancels the resolve entirely, including underflow detection.
        pop_s       = i_res_valid & ~fifo_empty_s & ~i_flush;
        underflow_s = i_res_valid & fifo_empty_s & ~i_flush;
        upd_s       = pop_s & i_res_branch;

        // Target only matters when the branch was actually taken.
        target_miss_s = i_res_taken & (head_target_s != i_res_target);
        mispredict_s  = upd_s & ((head_rec_s.taken != i_res_taken) | target_miss_s);

        // A mispredict empties the queue, so a same-cycle push is wrong-path.
        push_s  = i_push_valid & o_push_ready & ~fifo_full_s & (state_r == ST_RUN)
                  & ~i_flush & ~mispredict_s;
        clear_s = i_flush | mispredict_s;

        if (i_res_taken) begin
            redirect_pc_s = i_res_target;
        end else begin
            redirect_pc_s = head_pc_s + ADDR_WIDTH'(INSN_BYTES);
        end
    end

    pred_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_pred_fifo (
        .clk       (i_clk),
        .rst       (i_arst),
        .clear     (clear_s),
        .push      (push_s),
        .push_data (push_rec_s),
        .pop       (pop_s),
        .head_data (head_bits_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .full_next (fifo_full_next_s)
    );

    // RUN/RECOVER FSM: RECOVER lasts exactly one cycle after a mispredict.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_r <= ST_RUN;
        end else if (i_flush) begin
            state_r <= ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mispredict_s) begin
                        state_r <= ST_RECOVER;
                    end
                end
                ST_RECOVER: state_r <= ST_RUN;
                default:    state_r <= ST_RUN;
            endcase
        end
    end

    // Registered redirect, training port, ready, underflow and counters.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            o_push_ready     <= 1'b0;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= {ADDR_WIDTH{1'b0}};
            o_upd_valid      <= 1'b0;
            o_upd_taken      <= 1'b0;
            o_upd_pc         <= {ADDR_WIDTH{1'b0}};
            o_upd_target     <= {ADDR_WIDTH{1'b0}};
            o_upd_way        <= 2'b00;
            o_underflow      <= 1'b0;
            o_br_count       <= 32'd0;
            o_mp_count       <= 32'd0;
        end else begin
            // Ready reflects occupancy after this edge, so it equals "not full".
            o_push_ready     <= ~fifo_full_next_s;
            o_redirect_valid <= mispredict_s;
            o_upd_valid      <= upd_s;
            if (mispredict_s) begin
                o_redirect_pc <= redirect_pc_s;
                o_mp_count    <= sat_inc32(o_mp_count);
            end
            if (upd_s) begin
                o_upd_pc     <= head_pc_s;
                o_upd_target <= i_res_target;
                o_upd_taken  <= i_res_taken;
                o_upd_way    <= head_rec_s.way;
                o_br_count   <= sat_inc32(o_br_count);
            end
            if (underflow_s) begin
                o_underflow <= 1'b1;
            end
        end
    end

endmodule
